// File: rtl/modport_buffer_pkg.sv
// Shared types and constants for the registered two-entry stream skid buffer.
package modport_buffer_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] data;
    logic                          block;
  } beat_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] data;
    logic                          valid;
  } maybe_t;

endpackage

// File: rtl/modport_buffer_if.sv
// valid/ready/block stream interface; "out" is the producer side, "in" the consumer side.
interface modport_buffer_if
  import modport_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  block;

  modport out  (output valid, output data, output block, input  ready);
  modport in   (input  valid, input  data, input  block, output ready);
  modport view (input  valid, input  data, input  block, input  ready);

endinterface

// File: rtl/modport_buffer.sv
// Two-entry skid buffer: every output, including upstream ready, comes straight from a flop.
// Full throughput with no combinational path between the upstream and downstream sides.
module modport_buffer
  import modport_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  modport_buffer_if.in          up,
  modport_buffer_if.out         dn,
  output logic                  peek_valid,
  output logic [DATA_WIDTH-1:0] peek_data,
  output logic [1:0]            count
);

  logic                  main_v, skid_v, rdy;
  logic [DATA_WIDTH-1:0] main_d, skid_d;
  logic                  main_b, skid_b;

  logic                  main_v_n, skid_v_n;
  logic [DATA_WIDTH-1:0] main_d_n, skid_d_n;
  logic                  main_b_n, skid_b_n;

  logic up_xfer, dn_xfer;

  assign up_xfer = up.valid && rdy;
  assign dn_xfer = main_v && dn.ready;

  always_comb begin
    main_v_n = main_v;
    main_d_n = main_d;
    main_b_n = main_b;
    skid_v_n = skid_v;
    skid_d_n = skid_d;
    skid_b_n = skid_b;
    if (skid_v) begin
      // rdy is low here, so the skid entry is the only candidate for main
      if (dn_xfer) begin
        main_d_n = skid_d;
        main_b_n = skid_b;
        skid_v_n = 1'b0;
      end
    end else if (main_v && !dn_xfer) begin
      if (up_xfer) begin
        skid_v_n = 1'b1;
        skid_d_n = up.data;
        skid_b_n = up.block;
      end
    end else begin
      main_v_n = up_xfer;
      if (up_xfer) begin
        main_d_n = up.data;
        main_b_n = up.block;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_v <= 1'b0;
      main_d <= '0;
      main_b <= 1'b0;
      skid_v <= 1'b0;
      skid_d <= '0;
      skid_b <= 1'b0;
      rdy    <= 1'b0;
      count  <= 2'd0;
    end else begin
      main_v <= main_v_n;
      main_d <= main_d_n;
      main_b <= main_b_n;
      skid_v <= skid_v_n;
      skid_d <= skid_d_n;
      skid_b <= skid_b_n;
      rdy    <= !skid_v_n;
      count  <= {1'b0, main_v_n} + {1'b0, skid_v_n};
    end
  end

  assign up.ready   = rdy;
  assign dn.valid   = main_v;
  assign dn.data    = main_d;
  assign dn.block   = main_b;
  assign peek_valid = main_v;
  assign peek_data  = main_d;

endmodule

// File: tb/tb_modport_buffer.sv
// Directed bench for modport_buffer: reset, streaming, backpressure, drain, replace, async reset.
module tb_modport_buffer;
  import modport_buffer_pkg::*;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          peek_valid;
  logic [DW-1:0] peek_data;
  logic [1:0]    count;

  int total;
  int fails;

  modport_buffer_if #(.DATA_WIDTH(DW)) up_if ();
  modport_buffer_if #(.DATA_WIDTH(DW)) dn_if ();

  modport_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .up        (up_if),
    .dn        (dn_if),
    .peek_valid(peek_valid),
    .peek_data (peek_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic b);
    up_if.valid = 1'b1;
    up_if.data  = d;
    up_if.block = b;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic b,
                         input logic [1:0] c);
    chk({tag, ".out_valid"}, 64'(dn_if.valid), 64'(v));
    if (v) begin
      chk({tag, ".out_data"},  64'(dn_if.data),  64'(d));
      chk({tag, ".out_block"}, 64'(dn_if.block), 64'(b));
      chk({tag, ".peek_data"}, 64'(peek_data),   64'(d));
    end
    chk({tag, ".peek_valid"}, 64'(peek_valid), 64'(v));
    chk({tag, ".count"},      64'(count),      64'(c));
  endtask

  initial begin
    total       = 0;
    fails       = 0;
    rst         = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    up_if.block = 1'b0;
    dn_if.ready = 1'b0;

    // reset held for three cycles
    step(); step(); step();
    chk_out("rst", 1'b0, '0, 1'b0, 2'd0);
    chk("rst.in_ready", 64'(up_if.ready), 64'd0);
    rst = 1'b1;
    step();
    chk("rel.in_ready", 64'(up_if.ready), 64'd1);
    chk_out("rel", 1'b0, '0, 1'b0, 2'd0);

    // streaming with downstream always ready
    dn_if.ready = 1'b1;
    send(32'h11, 1'b0);
    step();
    chk_out("s11", 1'b1, 32'h11, 1'b0, 2'd1);
    send(32'h22, 1'b1);
    step();
    chk_out("s22", 1'b1, 32'h22, 1'b1, 2'd1);
    send(32'h33, 1'b0);
    step();
    chk_out("s33", 1'b1, 32'h33, 1'b0, 2'd1);
    chk("s33.in_ready", 64'(up_if.ready), 64'd1);
    up_if.valid = 1'b0;
    step();
    chk_out("sdone", 1'b0, '0, 1'b0, 2'd0);

    // backpressure fill
    dn_if.ready = 1'b0;
    send(32'hA0, 1'b1);
    step();
    chk_out("fA0", 1'b1, 32'hA0, 1'b1, 2'd1);
    chk("fA0.in_ready", 64'(up_if.ready), 64'd1);
    send(32'hB0, 1'b0);
    step();
    chk_out("fB0", 1'b1, 32'hA0, 1'b1, 2'd2);
    chk("fB0.in_ready", 64'(up_if.ready), 64'd0);
    send(32'hC0, 1'b1);
    step();
    chk_out("fC0", 1'b1, 32'hA0, 1'b1, 2'd2);
    chk("fC0.in_ready", 64'(up_if.ready), 64'd0);

    // drain from full; C0 is still offered and must follow B0
    dn_if.ready = 1'b1;
    step();
    chk_out("dB0", 1'b1, 32'hB0, 1'b0, 2'd1);
    chk("dB0.in_ready", 64'(up_if.ready), 64'd1);
    step();
    chk_out("dC0", 1'b1, 32'hC0, 1'b1, 2'd1);
    up_if.valid = 1'b0;
    step();
    chk_out("dempty", 1'b0, '0, 1'b0, 2'd0);

    // simultaneous accept and drain with one entry
    dn_if.ready = 1'b0;
    send(32'h55, 1'b0);
    step();
    chk_out("r55", 1'b1, 32'h55, 1'b0, 2'd1);
    dn_if.ready = 1'b1;
    send(32'h66, 1'b1);
    step();
    chk_out("r66", 1'b1, 32'h66, 1'b1, 2'd1);
    up_if.valid = 1'b0;
    step();
    chk_out("rempty", 1'b0, '0, 1'b0, 2'd0);

    // asynchronous reset while full
    dn_if.ready = 1'b0;
    send(32'h77, 1'b1);
    step();
    send(32'h88, 1'b0);
    step();
    chk_out("m88", 1'b1, 32'h77, 1'b1, 2'd2);
    up_if.valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_out("mrst", 1'b0, '0, 1'b0, 2'd0);
    chk("mrst.in_ready", 64'(up_if.ready), 64'd0);
    #3;
    rst = 1'b1;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("mpost", 1'b0, '0, 1'b0, 2'd0);
    end
    send(32'h99, 1'b0);
    step();
    chk_out("m99", 1'b1, 32'h99, 1'b0, 2'd1);
    up_if.valid = 1'b0;
    step();
    chk_out("mend", 1'b0, '0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
